// File: rtl/fifo_wr_ctrl_if.sv
// Write-side port bundle of the async FIFO: producer request, the read
// domain's Gray pointer, and everything the write controller drives back.
// The almost_full signal exists only when FIFO_ALMOST_FULL_EN is defined.
interface fifo_wr_ctrl_if #(
  parameter int DEPTH = 32
);
  localparam int AW = $clog2(DEPTH);

  logic          wr_en;
  logic [AW:0]   rd_gray_ptr;
  logic [AW:0]   wr_ptr;
  logic [AW:0]   wr_gray_ptr;
  logic          full;
  logic          wr_ack;
  logic          overflow;
  logic [AW:0]   wr_level;
`ifdef FIFO_ALMOST_FULL_EN
  logic          almost_full;

  modport slave (
    input  wr_en, rd_gray_ptr,
    output wr_ptr, wr_gray_ptr, full, wr_ack, overflow, wr_level, almost_full
  );

  modport master (
    output wr_en, rd_gray_ptr,
    input  wr_ptr, wr_gray_ptr, full, wr_ack, overflow, wr_level, almost_full
  );
`else
  modport slave (
    input  wr_en, rd_gray_ptr,
    output wr_ptr, wr_gray_ptr, full, wr_ack, overflow, wr_level
  );

  modport master (
    output wr_en, rd_gray_ptr,
    input  wr_ptr, wr_gray_ptr, full, wr_ack, overflow, wr_level
  );
`endif
endinterface

// File: rtl/fifo_wr_ctrl.sv
// Write-domain controller of the async FIFO (single clock wr_clk).
// Owns the binary/Gray write pointer, synchronises the read Gray pointer,
// and produces full, wr_ack, overflow and the write-side fill level.
// Optional feature macro: FIFO_ALMOST_FULL_EN adds a registered almost_full
// flag asserted when the fill level reaches AF_LEVEL.
module fifo_wr_ctrl #(
  parameter int DEPTH       = 32,
  parameter int SYNC_STAGES = 2,
  parameter int AF_LEVEL    = 28
) (
  input  logic          wr_clk,
  input  logic          wr_rst,
  fifo_wr_ctrl_if.slave bus
);

  localparam int AW = $clog2(DEPTH);
  localparam int PW = AW + 1;

  // Elaboration-time parameter legality checks.
  if (DEPTH < 4 || (DEPTH & (DEPTH - 1)) != 0) begin : g_bad_depth
    $error("fifo_wr_ctrl: DEPTH must be a power of 2 and at least 4");
  end
  if (SYNC_STAGES < 2) begin : g_bad_sync
    $error("fifo_wr_ctrl: SYNC_STAGES must be at least 2");
  end
  if (AF_LEVEL < 1 || AF_LEVEL > DEPTH - 1) begin : g_bad_af
    $error("fifo_wr_ctrl: AF_LEVEL must lie in 1..DEPTH-1");
  end

  // Gray to binary: each binary bit is the XOR of all Gray bits above and at it.
  function automatic logic [PW-1:0] g2b(input logic [PW-1:0] g);
    logic [PW-1:0] b;
    b[PW-1] = g[PW-1];
    for (int i = PW - 2; i >= 0; i--) begin
      b[i] = b[i+1] ^ g[i];
    end
    return b;
  endfunction

  // Binary to Gray.
  function automatic logic [PW-1:0] b2g(input logic [PW-1:0] b);
    return b ^ (b >> 1);
  endfunction

  logic [PW-1:0] sync_q [SYNC_STAGES];
  logic [PW-1:0] rq;
  logic [PW-1:0] rq_bin;

  logic [PW-1:0] wr_ptr_q;
  logic [PW-1:0] wr_gray_q;
  logic [PW-1:0] wr_level_q;
  logic          full_q;
  logic          wr_ack_q;
  logic          overflow_q;

  logic          wr_inc;
  logic [PW-1:0] wbin_n;
  logic [PW-1:0] wgray_n;
  logic [PW-1:0] full_gray;
  logic [PW-1:0] level_n;
  logic          full_n;

  // Plain flop chain bringing the read Gray pointer into wr_clk; no logic between stages.
  always_ff @(posedge wr_clk or posedge wr_rst) begin
    if (wr_rst) begin
      for (int i = 0; i < SYNC_STAGES; i++) begin
        sync_q[i] <= '0;
      end
    end else begin
      sync_q[0] <= bus.rd_gray_ptr;
      for (int i = 1; i < SYNC_STAGES; i++) begin
        sync_q[i] <= sync_q[i-1];
      end
    end
  end

  assign rq     = sync_q[SYNC_STAGES-1];
  assign rq_bin = g2b(rq);

  // Next pointer, full and level from the registered full and the synchronised read pointer.
  always_comb begin
    wr_inc    = bus.wr_en & ~full_q;
    wbin_n    = wr_ptr_q + PW'(wr_inc);
    wgray_n   = b2g(wbin_n);
    // Full when the write pointer is exactly one lap ahead: top two Gray bits inverted.
    full_gray = {~rq[PW-1:PW-2], rq[PW-3:0]};
    full_n    = (wgray_n == full_gray);
    // Modulo subtraction; the synchroniser lag can only make this read high, never low.
    level_n   = wbin_n - rq_bin;
  end

  // Pointer, flag and level registers, all updated on every edge.
  always_ff @(posedge wr_clk or posedge wr_rst) begin
    if (wr_rst) begin
      wr_ptr_q   <= '0;
      wr_gray_q  <= '0;
      wr_level_q <= '0;
      full_q     <= 1'b0;
      wr_ack_q   <= 1'b0;
      overflow_q <= 1'b0;
    end else begin
      wr_ptr_q   <= wbin_n;
      wr_gray_q  <= wgray_n;
      wr_level_q <= level_n;
      full_q     <= full_n;
      wr_ack_q   <= wr_inc;
      overflow_q <= bus.wr_en & full_q;
    end
  end

  assign bus.wr_ptr      = wr_ptr_q;
  assign bus.wr_gray_ptr = wr_gray_q;
  assign bus.wr_level    = wr_level_q;
  assign bus.full        = full_q;
  assign bus.wr_ack      = wr_ack_q;
  assign bus.overflow    = overflow_q;

`ifdef FIFO_ALMOST_FULL_EN
  localparam logic [PW-1:0] AF_THR = PW'(AF_LEVEL);

  logic almost_full_q;

  // Almost-full threshold on the same next-level value that feeds wr_level.
  always_ff @(posedge wr_clk or posedge wr_rst) begin
    if (wr_rst) begin
      almost_full_q <= 1'b0;
    end else begin
      almost_full_q <= (level_n >= AF_THR);
    end
  end

  assign bus.almost_full = almost_full_q;
`endif

endmodule

// File: tb/tb_fifo_wr_ctrl.sv
// Bench for fifo_wr_ctrl (DEPTH=8, SYNC_STAGES=2, AF_LEVEL=6).
// Reference model: integer write/read counts plus a history of read counts
// sampled at each edge; the write side sees the read count SYNC edges late.
module tb_fifo_wr_ctrl;

  localparam int DEPTH = 8;
  localparam int SYNC  = 2;
  localparam int AF    = 6;

  logic wr_clk = 1'b0;
  logic wr_rst = 1'b1;

  fifo_wr_ctrl_if #(.DEPTH(DEPTH)) bus();

  fifo_wr_ctrl #(
    .DEPTH      (DEPTH),
    .SYNC_STAGES(SYNC),
    .AF_LEVEL   (AF)
  ) dut (
    .wr_clk(wr_clk),
    .wr_rst(wr_rst),
    .bus   (bus)
  );

  always #5 wr_clk = ~wr_clk;

  int checks   = 0;
  int failures = 0;

  // Model state
  int wcnt;
  int rcnt;
  int hist[$];
  int m_ack, m_ovf, m_full, m_level, m_af;

  typedef struct {
    bit wr_en;
    int rd;
    int ptr;
    int gray;
    bit full;
    bit ack;
    bit ovf;
    int level;
  } vec_t;

  vec_t tbl[15];

  function automatic int gray4(input int b);
    int v;
    v = b & 15;
    return v ^ (v >> 1);
  endfunction

  task automatic chk(input string nm, input int act, input int exp);
    checks++;
    if (act != exp) begin
      failures++;
      $display("FAIL %s: got %0d expected %0d (t=%0t)", nm, act, exp, $time);
    end
  endtask

  task automatic model_reset();
    wcnt    = 0;
    rcnt    = 0;
    hist.delete();
    m_ack   = 0;
    m_ovf   = 0;
    m_full  = 0;
    m_level = 0;
    m_af    = 0;
  endtask

  task automatic check_all_zero(input string tag);
    chk({tag, "_ptr"},   int'(bus.wr_ptr),      0);
    chk({tag, "_gray"},  int'(bus.wr_gray_ptr), 0);
    chk({tag, "_full"},  int'(bus.full),        0);
    chk({tag, "_ack"},   int'(bus.wr_ack),      0);
    chk({tag, "_ovf"},   int'(bus.overflow),    0);
    chk({tag, "_level"}, int'(bus.wr_level),    0);
`ifdef FIFO_ALMOST_FULL_EN
    chk({tag, "_af"},    int'(bus.almost_full), 0);
`endif
  endtask

  // One clock: drive rd pointer from rcnt, advance model, compare after the edge.
  task automatic step();
    int rseen;
    bit inc;
    bus.rd_gray_ptr = 4'(gray4(rcnt));
    rseen   = (hist.size() >= SYNC) ? hist[hist.size() - SYNC] : 0;
    inc     = bus.wr_en && (m_full == 0);
    m_ovf   = (bus.wr_en && m_full != 0) ? 1 : 0;
    m_ack   = int'(inc);
    wcnt    = wcnt + int'(inc);
    m_level = wcnt - rseen;
    m_full  = (m_level == DEPTH) ? 1 : 0;
    m_af    = (m_level >= AF) ? 1 : 0;
    hist.push_back(rcnt);
    @(posedge wr_clk);
    #1;
    chk("m_ptr",   int'(bus.wr_ptr),      wcnt & 15);
    chk("m_gray",  int'(bus.wr_gray_ptr), gray4(wcnt));
    chk("m_full",  int'(bus.full),        m_full);
    chk("m_ack",   int'(bus.wr_ack),      m_ack);
    chk("m_ovf",   int'(bus.overflow),    m_ovf);
    chk("m_level", int'(bus.wr_level),    m_level);
`ifdef FIFO_ALMOST_FULL_EN
    chk("m_af",    int'(bus.almost_full), m_af);
`endif
  endtask

  task automatic do_reset();
    bus.wr_en       = 1'b0;
    bus.rd_gray_ptr = '0;
    wr_rst          = 1'b1;
    model_reset();
    @(posedge wr_clk);
    #1;
    wr_rst = 1'b0;
  endtask

  initial begin
    // Table: fill, overflow, one read and its synchroniser lag, then wrap write.
    for (int i = 0; i < 8; i++) begin
      tbl[i] = '{wr_en:1'b1, rd:0, ptr:i+1, gray:gray4(i+1), full:(i == 7),
                 ack:1'b1, ovf:1'b0, level:i+1};
    end
    for (int i = 8; i < 11; i++) begin
      tbl[i] = '{wr_en:1'b1, rd:0, ptr:8, gray:12, full:1'b1,
                 ack:1'b0, ovf:1'b1, level:8};
    end
    tbl[11] = '{wr_en:1'b0, rd:1, ptr:8, gray:12, full:1'b1, ack:1'b0, ovf:1'b0, level:8};
    tbl[12] = '{wr_en:1'b0, rd:1, ptr:8, gray:12, full:1'b1, ack:1'b0, ovf:1'b0, level:8};
    tbl[13] = '{wr_en:1'b0, rd:1, ptr:8, gray:12, full:1'b0, ack:1'b0, ovf:1'b0, level:7};
    tbl[14] = '{wr_en:1'b1, rd:1, ptr:9, gray:13, full:1'b1, ack:1'b1, ovf:1'b0, level:8};

    // Power-on reset
    bus.wr_en       = 1'b0;
    bus.rd_gray_ptr = '0;
    model_reset();
    repeat (2) @(posedge wr_clk);
    #1;
    check_all_zero("por");
    wr_rst = 1'b0;

    // First edge after release with wr_en=0 keeps everything at 0
    bus.wr_en = 1'b0;
    step();
    check_all_zero("post_rst");

    // Table-driven fill / overflow / drain / wrap
    for (int i = 0; i < 15; i++) begin
      bus.wr_en = tbl[i].wr_en;
      rcnt      = tbl[i].rd;
      step();
      chk($sformatf("tbl%0d_ptr", i),   int'(bus.wr_ptr),      tbl[i].ptr);
      chk($sformatf("tbl%0d_gray", i),  int'(bus.wr_gray_ptr), tbl[i].gray);
      chk($sformatf("tbl%0d_full", i),  int'(bus.full),        int'(tbl[i].full));
      chk($sformatf("tbl%0d_ack", i),   int'(bus.wr_ack),      int'(tbl[i].ack));
      chk($sformatf("tbl%0d_ovf", i),   int'(bus.overflow),    int'(tbl[i].ovf));
      chk($sformatf("tbl%0d_level", i), int'(bus.wr_level),    tbl[i].level);
    end

    // Reset asserted mid-cycle with a full FIFO: outputs clear before any edge
    #2;
    wr_rst = 1'b1;
    #1;
    check_all_zero("async_rst");
    do_reset();
    step();
    check_all_zero("after_async_rst");

    // Writes held every cycle while the reader follows one step per cycle
    do_reset();
    bus.wr_en = 1'b1;
    for (int i = 0; i < 40; i++) begin
      if (rcnt < wcnt) rcnt++;
      step();
      chk("t5_no_ovf", int'(bus.overflow), 0);
      chk("t5_level_bound", (int'(bus.wr_level) <= DEPTH) ? 1 : 0, 1);
    end

`ifdef FIFO_ALMOST_FULL_EN
    // Almost-full rises on the 6th write and drops 3 edges after one read
    do_reset();
    bus.wr_en = 1'b1;
    for (int i = 1; i <= 6; i++) begin
      step();
      chk($sformatf("af_wr%0d", i), int'(bus.almost_full), (i == 6) ? 1 : 0);
    end
    bus.wr_en = 1'b0;
    rcnt = 1;
    for (int i = 1; i <= 3; i++) begin
      step();
      chk($sformatf("af_rd%0d", i), int'(bus.almost_full), (i == 3) ? 0 : 1);
    end
`endif

    // Randomised traffic in phases with different write/read biases
    do_reset();
    for (int ph = 0; ph < 4; ph++) begin
      int pw;
      int pr;
      pw = (ph == 0) ? 90 : (ph == 1) ? 50 : (ph == 2) ? 95 : 30;
      pr = (ph == 0) ? 20 : (ph == 1) ? 50 : (ph == 2) ? 60 : 90;
      for (int c = 0; c < 200; c++) begin
        bus.wr_en = (int'($urandom_range(0, 99)) < pw);
        if (rcnt < wcnt && int'($urandom_range(0, 99)) < pr) rcnt++;
        step();
      end
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
